// File: rtl/l1d_victim_alloc_pkg.sv
// rvh_l1d_victim_pkg: shared types for the L1D refill victim allocator.
//   state_e  - allocator FSM states
//   victim_t - captured victim {set_idx, way}; fields are sized for the
//              largest supported cache and the top slices them to SW/WW.
package rvh_l1d_victim_pkg;

  localparam int SW_MAX = 16;  // up to 64K sets
  localparam int WW_MAX = 3;   // up to 8 ways

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVICT = 2'd1,
    ALLOC = 2'd2,
    TOUCH = 2'd3
  } state_e;

  typedef struct packed {
    logic [SW_MAX-1:0] set_idx;
    logic [WW_MAX-1:0] way;
  } victim_t;

endpackage

// File: rtl/l1d_victim_alloc_way_prio_enc.sv
// l1d_way_prio_enc: lowest-index-zero priority encoder over a way vector.
//   vec_i   [N_WAYS] per-way bits (a zero marks a candidate way)
//   found_o          at least one bit of vec_i is zero
//   way_o   [WW]     index of the lowest zero bit (0 when none found)
module l1d_way_prio_enc #(
  parameter int N_WAYS = 4,
  localparam int WW = $clog2(N_WAYS)
) (
  input  logic [N_WAYS-1:0] vec_i,
  output logic              found_o,
  output logic [WW-1:0]     way_o
);

  // Scan from the top down so the lowest zero index is written last.
  always_comb begin
    found_o = 1'b0;
    way_o   = '0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (!vec_i[i]) begin
        found_o = 1'b1;
        way_o   = WW'(i);
      end
    end
  end

endmodule

// File: rtl/l1d_victim_alloc.sv
// l1d_victim_alloc: L1D refill victim allocator in front of the per-set PLRU.
// Picks a victim way on a miss, runs the dirty-eviction handshake, grants the
// way to refill, then touches the PLRU. Hit touches share the PLRU touch port
// and always win over the deferred victim touch.
//   clk, rst                        clock, synchronous active-high reset
//   req_*                           miss request (valid/ready, set, way valid/dirty)
//   hit_touch_*                     hit-path PLRU touch
//   plru_touch_*_o, plru_alloc_way_i  PLRU touch port / PLRU way for req_set_i
//   evict_*                         dirty-victim writeback handshake
//   alloc_*                         refill way grant handshake
// Build option: L1D_VICTIM_INVALID_FIRST_EN - prefer the lowest invalid way
// over the PLRU way; when undefined the PLRU way is always the victim.
module l1d_victim_alloc
  import rvh_l1d_victim_pkg::*;
#(
  parameter int N_WAYS = 4,
  parameter int N_SETS = 64,
  localparam int SW = $clog2(N_SETS),
  localparam int WW = $clog2(N_WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [SW-1:0]     req_set_i,
  input  logic [N_WAYS-1:0] req_way_valid_i,
  input  logic [N_WAYS-1:0] req_way_dirty_i,
  input  logic              hit_touch_valid_i,
  input  logic [SW-1:0]     hit_touch_set_i,
  input  logic [WW-1:0]     hit_touch_way_i,
  output logic              plru_touch_valid_o,
  output logic [SW-1:0]     plru_touch_addr_o,
  output logic [WW-1:0]     plru_touch_way_o,
  input  logic [WW-1:0]     plru_alloc_way_i,
  output logic              evict_valid_o,
  input  logic              evict_ready_i,
  output logic [SW-1:0]     evict_set_o,
  output logic [WW-1:0]     evict_way_o,
  output logic              alloc_valid_o,
  input  logic              alloc_ready_i,
  output logic [SW-1:0]     alloc_set_o,
  output logic [WW-1:0]     alloc_way_o
);

  state_e        state_q, state_d;
  victim_t       vic_q, vic_d;
  logic [WW-1:0] vway;
  logic          vdirty;
  logic          req_fire;

`ifdef L1D_VICTIM_INVALID_FIRST_EN
  logic          inv_found;
  logic [WW-1:0] inv_way;

  l1d_way_prio_enc #(.N_WAYS(N_WAYS)) u_inv_enc (
    .vec_i   (req_way_valid_i),
    .found_o (inv_found),
    .way_o   (inv_way)
  );

  assign vway = inv_found ? inv_way : plru_alloc_way_i;
`else
  assign vway = plru_alloc_way_i;
`endif

  // Only a line that is both valid and dirty needs writing back.
  assign vdirty   = req_way_valid_i[vway] & req_way_dirty_i[vway];
  assign req_fire = req_valid_i & req_ready_o;

  // Hit touches own the PLRU port; blocking accepts then keeps the
  // plru_alloc_way_i lookup (addressed by req_set_i) coherent with the accept.
  assign req_ready_o = (state_q == IDLE) & ~hit_touch_valid_i & ~rst;

  always_comb begin
    state_d = state_q;
    vic_d   = vic_q;
    unique case (state_q)
      IDLE: if (req_fire) begin
        vic_d.set_idx = SW_MAX'(req_set_i);
        vic_d.way     = WW_MAX'(vway);
        state_d       = vdirty ? EVICT : ALLOC;
      end
      EVICT: if (evict_ready_i) state_d = ALLOC;
      ALLOC: if (alloc_ready_i) state_d = TOUCH;
      TOUCH: if (!hit_touch_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vic_q   <= '0;
    end else begin
      state_q <= state_d;
      vic_q   <= vic_d;
    end
  end

  // Valids are masked during reset so nothing leaks out of an aborted request.
  assign evict_valid_o = (state_q == EVICT) & ~rst;
  assign alloc_valid_o = (state_q == ALLOC) & ~rst;
  assign evict_set_o   = vic_q.set_idx[SW-1:0];
  assign evict_way_o   = vic_q.way[WW-1:0];
  assign alloc_set_o   = vic_q.set_idx[SW-1:0];
  assign alloc_way_o   = vic_q.way[WW-1:0];

  always_comb begin
    plru_touch_valid_o = 1'b0;
    plru_touch_addr_o  = req_set_i;
    plru_touch_way_o   = '0;
    if (hit_touch_valid_i) begin
      plru_touch_valid_o = 1'b1;
      plru_touch_addr_o  = hit_touch_set_i;
      plru_touch_way_o   = hit_touch_way_i;
    end else if ((state_q == TOUCH) && !rst) begin
      plru_touch_valid_o = 1'b1;
      plru_touch_addr_o  = vic_q.set_idx[SW-1:0];
      plru_touch_way_o   = vic_q.way[WW-1:0];
    end
  end

  // Upper struct bits are zero-filled for narrow configurations.
  logic unused_vic_bits;
  assign unused_vic_bits = ^vic_q;

endmodule

// File: doc/l1d_victim_alloc.md
# l1d_victim_alloc

Refill victim allocator for the L1 data cache, sitting directly upstream of the per-set PLRU replacement block. On a miss it picks a victim way for the target set (first invalid way, else the PLRU way), sequences a dirty-line eviction handshake if needed, and grants the way to the refill path. After the grant it touches the PLRU, and it also arbitrates hit-path PLRU touches onto the single PLRU touch port.

## Interface
- N_WAYS, 4, associativity; legal values are 2, 4 and 8 (the PLRU block supports only these).
- N_SETS, 64, number of sets; power of two, ≥2.
- SW = $clog2(N_SETS), WW = $clog2(N_WAYS).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  miss allocation request.
- req_ready_o  out  1  request accepted when valid & ready.
- req_set_i  in  SW  miss set index.
- req_way_valid_i  in  N_WAYS  valid bits of the set, sampled at accept.
- req_way_dirty_i  in  N_WAYS  dirty bits of the set, sampled at accept.
- hit_touch_valid_i  in  1  hit-path PLRU touch.
- hit_touch_set_i  in  SW  hit set.
- hit_touch_way_i  in  WW  hit way.
- plru_touch_valid_o  out  1  to PLRU touch_valid_i.
- plru_touch_addr_o  out  SW  to PLRU touch_addr_i.
- plru_touch_way_o  out  WW  to PLRU touch_way_i.
- plru_alloc_way_i  in  WW  from PLRU alloc_way_o; combinational for plru_touch_addr_o.
- evict_valid_o  out  1  dirty-victim writeback request.
- evict_ready_i  in  1  writeback accepted.
- evict_set_o  out  SW  eviction set.
- evict_way_o  out  WW  eviction way.
- alloc_valid_o  out  1  refill way grant.
- alloc_ready_i  in  1  grant consumed.
- alloc_set_o  out  SW  granted set.
- alloc_way_o  out  WW  granted way.

## Operation
- FSM states: IDLE, EVICT, ALLOC, TOUCH. Reset state is IDLE.
- Touch-port mux:
  - hit_touch_valid_i=1: hit set/way are forwarded and have absolute priority.
  - Otherwise, in TOUCH: the captured set/way is driven with valid=1.
  - Otherwise: plru_touch_addr_o = req_set_i and valid=0, so plru_alloc_way_i reflects the request set.
- req_ready_o = (state==IDLE) & ~hit_touch_valid_i & ~rst.
- IDLE, on accept: capture the set and compute the victim.
  - Victim = lowest-index way with req_way_valid_i=0; if no way is invalid, victim = plru_alloc_way_i.
  - If the victim is valid and dirty, go to EVICT; otherwise go to ALLOC.
- EVICT: evict_valid_o=1 with the captured set/way. On evict_ready_i, go to ALLOC.
- ALLOC: alloc_valid_o=1 with the captured set/way. On alloc_ready_i, go to TOUCH.
- TOUCH:
  - If hit_touch_valid_i=0: drive the victim touch and go to IDLE.
  - Otherwise: stay in TOUCH. The victim touch is deferred, never dropped.
- Payload outputs (set/way) are registered and remain stable while the matching valid is high and ready is low.
- valid must not drop before its handshake completes.
- Reset mid-operation: the FSM returns to IDLE and no touch or grant is emitted.

## Timing
- Reset values: evict_valid_o=0, alloc_valid_o=0, req_ready_o=0, set/way registers=0.
  - plru_touch_valid_o equals hit_touch_valid_i.
- Clean victim: accept at cycle T → alloc_valid_o at T+1.
- Dirty victim: evict_valid_o at T+1. Eviction handshake at cycle E → alloc_valid_o at E+1.
- Alloc handshake at cycle A → victim touch at A+1 if no hit touch that cycle → req_ready_o can be 1 at A+2.
- A single outstanding request at a time; no request pipelining.

## Configuration
- L1D_VICTIM_INVALID_FIRST_EN defined: invalid ways are preferred as described in Operation.
- Not defined: the victim is always plru_alloc_way_i. req_way_valid_i is used only to qualify the dirty check (victim valid & dirty → EVICT).

## Structure
- Package rvh_l1d_victim_pkg holds:
  - the FSM state enum typedef;
  - a packed struct {set, way} for the captured victim.
- One sub-module, l1d_way_prio_enc, parameterised by N_WAYS: lowest-index-zero priority encoder producing {found, way}.
- The PLRU block is instantiated outside this block, at cache top level.

## Test plan
Configuration for all tests: N_WAYS=4, N_SETS=64, macro defined unless stated.
- Req set 5, valid=4'b1011, dirty=0 → alloc_valid_o at T+1 with set 5, way 2 → touch {5,2} at A+1 → req_ready_o=1 at A+2.
- Req set 9, valid=4'hF, plru_alloc_way_i=3, dirty=4'b1000 → evict_valid_o {9,3} at T+1.
  - Hold evict_ready_i=0 for 3 cycles → payload stable.
  - Assert ready → alloc {9,3} on the next cycle.
- hit_touch_valid_i=1 (set 2, way 1) during TOUCH → PLRU sees {2,1}; the victim touch is issued on the first cycle hit_touch_valid_i=0.
- hit_touch_valid_i=1 in IDLE with req_valid_i=1 → req_ready_o=0, no accept, and the hit touch is forwarded unchanged.
- rst=1 while in EVICT → next cycle evict_valid_o=0, state IDLE, no touch emitted.
- Macro undefined, valid=4'b0001, plru_alloc_way_i=3, dirty=0 → alloc way 3.
